// File: rtl/data_mem_responder.sv
// Data-memory responder for the multi-cycle core.
// Serves one load/store at a time over valid/ready request and response
// channels; each access commits LATENCY cycles after it is accepted.
// Optional build macro DMEM_ERR_EN: out-of-range addresses (>= DEPTH) are
// flagged on rsp_err, return 0 and suppress stores. Without it, addresses
// wrap modulo DEPTH and rsp_err stays 0.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | access latency countdown, commit when cnt reaches 0
// RESP  | response presented, held until the core takes it
module data_mem_responder #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              addr_bad;

  // Boot contents restored on every reset; a committed store does not survive it.
  function automatic logic [DATA_W-1:0] init_word(input int i);
    case (i)
      0:       return DATA_W'(8'hEC);
      1:       return DATA_W'(8'h0A);
      2:       return DATA_W'(8'h02);
      default: return '0;
    endcase
  endfunction

  assign idx = addr_q[IDX_W-1:0];

`ifdef DMEM_ERR_EN
  // Widened compare so DEPTH == 2^ADDR_W does not overflow.
  assign addr_bad = ({1'b0, addr_q} >= (ADDR_W+1)'(DEPTH));
`else
  logic unused_addr_hi;
  assign addr_bad       = 1'b0;
  assign unused_addr_hi = ^addr_q;
`endif

  // Ready only while idle and not being reset.
  assign req_ready = (state == IDLE) && !reset;

  // Request/response FSM, latency counter and memory array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= init_word(i);
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(LATENCY - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= addr_bad;
            if (addr_bad) begin
              rsp_rdata <= '0;
            end else if (we_q) begin
              mem[idx]  <= wdata_q;
              rsp_rdata <= wdata_q;
            end else begin
              rsp_rdata <= mem[idx];
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a monitor pushes expected
// responses from a reference memory at each accept and pops/compares them
// at each response handshake; directed sequences add timing checks.
module tb_data_mem_responder;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int LATENCY = 2;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  data_mem_responder #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] model [DEPTH];
  int                total = 0;
  int                bad = 0;
  int                cyc = 0;
  int                n_acc = 0;
  int                n_hs = 0;
  int                n_abort = 0;
  int                acc_edges[$];
  int                hs_edges[$];
  bit                rand_rdy = 1'b0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    model[0] = 8'hEC;
    model[1] = 8'h0A;
    model[2] = 8'h02;
  endfunction

  // Monitor: accepts feed the scoreboard, handshakes drain it.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      model_init();
      if (n_acc > n_hs) begin
        n_abort += n_acc - n_hs;
        n_acc = n_hs;
      end
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_data", 32'(rsp_rdata), 32'(prev_data));
        check("stall_err", 32'(rsp_err), 32'(prev_err));
      end
      if (n_acc > n_hs && req_ready) check("ready_busy", 32'(req_ready), 32'd0);
      if (req_valid && req_ready) begin
        exp_t e;
        int   ix;
        ix = int'(req_addr) % DEPTH;
        if (ERR_EN && int'(req_addr) >= DEPTH) begin
          e.data = '0;
          e.err  = 1'b1;
        end else if (req_we) begin
          model[ix] = req_wdata;
          e.data = req_wdata;
          e.err  = 1'b0;
        end else begin
          e.data = model[ix];
          e.err  = 1'b0;
        end
        sb_q.push_back(e);
        acc_edges.push_back(cyc + 1);
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        hs_edges.push_back(cyc + 1);
        n_hs++;
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_data", 32'(rsp_rdata), 32'(e.data));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_rdata;
      prev_err   = rsp_err;
    end
  end

  task automatic start_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic wait_accept();
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    start_req(we, addr, wd);
    wait_accept();
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_hs < n_acc && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (n_hs < n_acc) check("rsp_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_rdata", 32'(rsp_rdata), 32'd0);
    check("idle_err", 32'(rsp_err), 32'd0);

    // Load latency
    issue(1'b0, 8'd1, 8'h00);
    wait_done();
    check("load_latency", 32'(hs_edges[$] - acc_edges[$]), 32'(LATENCY + 1));

    // Store then load
    issue(1'b1, 8'd5, 8'h55);
    issue(1'b0, 8'd5, 8'h00);
    issue(1'b0, 8'd0, 8'h00);
    issue(1'b0, 8'd2, 8'h00);
    wait_done();

    // Backpressure with a pending request
    rsp_ready = 1'b0;
    issue(1'b0, 8'd0, 8'h00);
    begin
      int k = 0;
      while (!rsp_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("bp_valid_up", 32'(rsp_valid), 32'd1);
    end
    start_req(1'b0, 8'd2, 8'h00);
    repeat (4) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_accept();
    check("bp_accept_gap", 32'(acc_edges[$] - hs_edges[$]), 32'd1);
    wait_done();

    // Back-to-back loads
    issue(1'b0, 8'd0, 8'h00);
    issue(1'b0, 8'd1, 8'h00);
    issue(1'b0, 8'd2, 8'h00);
    check("b2b_gap1", 32'(acc_edges[$-1] - acc_edges[$-2]), 32'(LATENCY + 2));
    check("b2b_gap2", 32'(acc_edges[$] - acc_edges[$-1]), 32'(LATENCY + 2));
    wait_done();

    // Reset one cycle after a store is accepted
    issue(1'b1, 8'd5, 8'h77);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (LATENCY + 3) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    issue(1'b0, 8'd5, 8'h00);
    wait_done();

    // Out-of-range addresses: wrap or error depending on build
    issue(1'b0, 8'h13, 8'h00);
    issue(1'b1, 8'h13, 8'h3C);
    issue(1'b0, 8'h03, 8'h00);
    issue(1'b1, 8'h03, 8'h5A);
    issue(1'b0, 8'h13, 8'h00);
    wait_done();

    // Random traffic with random response backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end
    wait_done();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("abort_count", 32'(n_abort), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
